// File: rtl/acc_activation_packer.sv
// Requantizes accumulator partial sums (round, shift, optional ReLU, saturate)
// and packs SIZE activations per output word under a valid/ready handshake.
module acc_activation_packer #(
  parameter int unsigned SIZE              = 8,
  parameter int unsigned PARTIAL_SUM_WIDTH = 45,
  parameter int unsigned OUT_WIDTH         = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [3:0]                          num_rows,
  input  logic [5:0]                          shift,
  input  logic                                relu_en,
  input  logic                                psum_valid,
  input  logic signed [PARTIAL_SUM_WIDTH-1:0] psum_in,
  output logic                                psum_ready,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [SIZE*OUT_WIDTH-1:0]           out_data,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned EW = PARTIAL_SUM_WIDTH + 1;
  localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned DW = SIZE * OUT_WIDTH;
  localparam logic [CW-1:0] LAST_ELEM = CW'(SIZE - 1);
  localparam logic signed [EW-1:0] SAT_MAX =
    {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN =
    {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    OUTPUT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [3:0]             r_rows;
  logic [5:0]             r_shift;
  logic                   r_relu;
  logic [CW-1:0]          r_elem_cnt;
  logic [3:0]             r_row_cnt;
  logic [OUT_WIDTH-1:0]   r_slot [SIZE];
  logic [DW-1:0]          r_out_data;
  logic                   r_psum_ready;
  logic                   r_out_valid;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_accept;
  logic                   w_hs;
  logic                   w_last_elem;
  logic                   w_last_row;
  logic signed [EW-1:0]   w_ext;
  logic signed [EW-1:0]   w_rnd;
  logic signed [EW-1:0]   w_sum;
  logic signed [EW-1:0]   w_shr;
  logic signed [EW-1:0]   w_act;
  logic [OUT_WIDTH-1:0]   w_q;
  logic [DW-1:0]          w_word;

  assign w_accept    = r_psum_ready & psum_valid;
  assign w_hs        = r_out_valid & out_ready;
  assign w_last_elem = (r_elem_cnt == LAST_ELEM);
  // num_rows of 0 encodes 16 rows, so rows-1 wraps naturally to 4'hF
  assign w_last_row  = (r_row_cnt == (r_rows - 4'd1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = COLLECT;
      COLLECT: if (w_accept && w_last_elem) w_state_nxt = OUTPUT;
      OUTPUT:  if (w_hs) w_state_nxt = w_last_row ? IDLE : COLLECT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Requantization: round half up, arithmetic shift, optional ReLU, saturate
  always_comb begin
    w_ext = EW'(psum_in);
    w_rnd = '0;
    if (r_shift != 6'd0) w_rnd = EW'(1) << (r_shift - 6'd1);
    w_sum = w_ext + w_rnd;
    w_shr = w_sum >>> r_shift;
    w_act = (r_relu && w_shr[EW-1]) ? '0 : w_shr;
    if (w_act > SAT_MAX)      w_q = SAT_MAX[OUT_WIDTH-1:0];
    else if (w_act < SAT_MIN) w_q = SAT_MIN[OUT_WIDTH-1:0];
    else                      w_q = w_act[OUT_WIDTH-1:0];
  end

  // Completed word: stored slots with the element being accepted merged in
  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      w_word[i*OUT_WIDTH +: OUT_WIDTH] = (CW'(i) == r_elem_cnt) ? w_q : r_slot[i];
    end
  end

  // Datapath, counters and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rows       <= '0;
      r_shift      <= '0;
      r_relu       <= 1'b0;
      r_elem_cnt   <= '0;
      r_row_cnt    <= '0;
      r_out_data   <= '0;
      r_psum_ready <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      for (int unsigned i = 0; i < SIZE; i++) r_slot[i] <= '0;
    end else begin
      r_psum_ready <= (w_state_nxt == COLLECT);
      r_out_valid  <= (w_state_nxt == OUTPUT);
      r_busy       <= (w_state_nxt != IDLE);
      r_done       <= (r_state == OUTPUT) && w_hs && w_last_row;
      if (r_state == IDLE && start) begin
        r_rows     <= num_rows;
        r_shift    <= shift;
        r_relu     <= relu_en;
        r_elem_cnt <= '0;
        r_row_cnt  <= '0;
      end
      if (w_accept) begin
        r_slot[r_elem_cnt] <= w_q;
        r_elem_cnt         <= w_last_elem ? '0 : r_elem_cnt + CW'(1);
        if (w_last_elem) r_out_data <= w_word;
      end
      if (w_hs && !w_last_row) r_row_cnt <= r_row_cnt + 4'd1;
    end
  end

  assign psum_ready = r_psum_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_acc_activation_packer.sv
// Directed and randomized bench for acc_activation_packer against an
// arithmetic reference model of the requantize-and-pack function.
module tb_acc_activation_packer;

  localparam int unsigned SIZE = 8;
  localparam int unsigned PW   = 45;
  localparam int unsigned OW   = 8;
  localparam int unsigned DW   = SIZE * OW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [3:0]           num_rows;
  logic [5:0]           shift;
  logic                 relu_en;
  logic                 psum_valid;
  logic signed [PW-1:0] psum_in;
  logic                 psum_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic                 busy;
  logic                 done;

  always #5 clk = ~clk;

  acc_activation_packer #(
    .SIZE(SIZE), .PARTIAL_SUM_WIDTH(PW), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .shift(shift),
    .relu_en(relu_en), .psum_valid(psum_valid), .psum_in(psum_in),
    .psum_ready(psum_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [PW-1:0] g_psum [$];
  logic [DW-1:0]        g_exp  [$];
  int g_shift;
  bit g_relu;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: floor((p + 2^(s-1)) / 2^s), then ReLU, then clamp
  function automatic logic [OW-1:0] quant(input logic signed [PW-1:0] p, input int s, input bit relu);
    longint v, d, n, q, hi, lo;
    v = longint'(p);
    if (s > 0) begin
      d = longint'(1) <<< s;
      n = v + d / 2;
      q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
      v = q;
    end
    if (relu && v < 0) v = 0;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -(longint'(1) <<< (OW - 1));
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return OW'(v);
  endfunction

  task automatic build_expected(input int rows);
    logic [DW-1:0] w;
    g_exp.delete();
    for (int r = 0; r < rows; r++) begin
      w = '0;
      for (int i = 0; i < SIZE; i++) w[i*OW +: OW] = quant(g_psum[r*SIZE + i], g_shift, g_relu);
      g_exp.push_back(w);
    end
  endtask

  task automatic load_random(input int rows, input int s);
    longint v;
    g_psum.delete();
    for (int n = 0; n < rows * SIZE; n++) begin
      if ($urandom_range(2) == 0) begin
        v = longint'({$urandom, $urandom});
      end else begin
        v = (longint'($urandom_range(600)) - 300) <<< s;
        if (s > 0) v = v + (longint'({$urandom, $urandom}) & ((longint'(1) <<< s) - 1));
      end
      g_psum.push_back(PW'(v));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; psum_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic start_job(input int rows_cfg, input int s, input bit relu);
    g_shift = s; g_relu = relu;
    start = 1'b1; num_rows = 4'(rows_cfg); shift = 6'(s); relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0; num_rows = 4'($urandom); shift = 6'($urandom); relu_en = 1'($urandom_range(1));
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("ready_after_start", 64'(psum_ready), 64'd1);
  endtask

  // Streams g_psum with random gaps/stalls and checks every word and flag
  task automatic run_job(input int rows_cfg, input int gap_pct, input int stall_pct,
                         input int hold0, input bit poke);
    int rows, total, idx, word, cyc, hold;
    bit acc, hs, ov_due, prev_ov, prev_hs;
    logic [DW-1:0] prev_data;
    rows = (rows_cfg == 0) ? 16 : rows_cfg;
    total = rows * SIZE;
    build_expected(rows);
    idx = 0; word = 0; cyc = 0; hold = hold0;
    ov_due = 0; prev_ov = 0; prev_hs = 0; prev_data = '0;
    while (word < rows && cyc < 20000) begin
      psum_valid = (idx < total) && (int'($urandom_range(99)) >= gap_pct);
      psum_in    = psum_valid ? g_psum[idx] : PW'({$urandom, $urandom});
      out_ready  = (hold > 0) ? 1'b0 : (int'($urandom_range(99)) >= stall_pct);
      if (poke) begin
        start = 1'($urandom_range(1)); num_rows = 4'($urandom);
        shift = 6'($urandom_range(PW - 1)); relu_en = 1'($urandom_range(1));
      end
      if (ov_due) chk("ov_latency", 64'(out_valid), 64'd1);
      chk("done_midjob", 64'(done), 64'd0);
      chk("busy_midjob", 64'(busy), 64'd1);
      if (out_valid) chk("ready_in_output", 64'(psum_ready), 64'd0);
      else           chk("ready_in_collect", 64'(psum_ready), 64'd1);
      if (prev_ov && !prev_hs) chk("data_hold", out_data, prev_data);
      acc = psum_valid && psum_ready;
      hs  = out_valid && out_ready;
      if (hs) chk($sformatf("word%0d", word), out_data, g_exp[word]);
      prev_ov = out_valid; prev_hs = hs; prev_data = out_data;
      if (out_valid && word == 0 && hold > 0) hold--;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        ov_due = (idx % SIZE == 0);
      end else begin
        ov_due = 0;
      end
      if (hs) word++;
    end
    psum_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    chk("job_timeout", 64'(word), 64'(rows));
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("ready_idle", 64'(psum_ready), 64'd0);
    chk("ov_idle", 64'(out_valid), 64'd0);
    chk("data_retain", out_data, g_exp[rows-1]);
    @(posedge clk); #1;
    chk("done_single", 64'(done), 64'd0);
    chk("data_retain2", out_data, g_exp[rows-1]);
  endtask

  task automatic load_fixed(input int d [SIZE]);
    g_psum.delete();
    for (int i = 0; i < SIZE; i++) g_psum.push_back(PW'(d[i]));
  endtask

  initial begin
    int d34 [SIZE] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int d35 [SIZE] = '{24, -24, 23, -25, 8, 7, -8, -9};
    int d36 [SIZE] = '{1000, -1000, 127, -128, 128, -129, 0, -1};
    int rc, s;
    num_rows = '0; shift = '0; relu_en = 1'b0; psum_in = '0;
    do_reset();
    chk("rst_ready", 64'(psum_ready), 64'd0);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_data", out_data, 64'd0);

    // Back-to-back single word, identity quantization
    load_fixed(d34);
    start_job(1, 0, 0);
    run_job(1, 0, 0, 0, 0);
    chk("ramp_word", out_data, 64'h0706050403020100);

    // Rounding half up with shift 4
    load_fixed(d35);
    start_job(1, 4, 0);
    run_job(1, 0, 0, 0, 0);
    chk("round_word", out_data, 64'hFF00_0001_FE01_FF02);

    // Saturation without and with ReLU
    load_fixed(d36);
    start_job(1, 0, 0);
    run_job(1, 0, 0, 0, 0);
    chk("sat_word", out_data, 64'hFF00_807F_807F_807F);
    start_job(1, 0, 1);
    run_job(1, 0, 0, 0, 0);
    chk("relu_sat_word", out_data, 64'h0000_007F_007F_007F);

    // Two words with word 0 back-pressured for five cycles
    load_random(2, 3);
    start_job(2, 3, 0);
    run_job(2, 0, 0, 5, 0);

    // Reset after three accepted elements aborts the job
    start_job(1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      psum_valid = 1'b1; psum_in = PW'(i * 100 + 5);
      @(posedge clk); #1;
    end
    psum_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", 64'(psum_ready), 64'd0);
    chk("abort_ov", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_data", out_data, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'(done), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
    end
    load_random(1, 5);
    start_job(1, 5, 1);
    run_job(1, 20, 20, 0, 0);

    // Boundaries: 16 rows (num_rows=0) and maximum shift
    load_random(16, 44);
    start_job(0, 44, 0);
    run_job(0, 30, 30, 0, 1);

    // Randomized jobs with start/config poked while busy
    for (int t = 0; t < 6; t++) begin
      rc = int'($urandom_range(15));
      s  = int'($urandom_range(PW - 1));
      load_random((rc == 0) ? 16 : rc, s);
      start_job(rc, s, 1'($urandom_range(1)));
      run_job(rc, 30, 30, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
